// File: rtl/ncl_pkg.sv
// Shared dual-rail NCL types, encodings and FSM state type for the sequential multiplier.
package ncl_pkg;

    typedef struct packed {
        logic rail1;
        logic rail0;
    } dual_rail_logic;

    localparam dual_rail_logic DR_NULL    = '{rail1: 1'b0, rail0: 1'b0};
    localparam dual_rail_logic DR_ZERO    = '{rail1: 1'b0, rail0: 1'b1};
    localparam dual_rail_logic DR_ONE     = '{rail1: 1'b1, rail0: 1'b0};
    localparam dual_rail_logic DR_ILLEGAL = '{rail1: 1'b1, rail0: 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } mult_state_e;

    function automatic dual_rail_logic dr_encode(input logic b);
        return b ? DR_ONE : DR_ZERO;
    endfunction

    // Only meaningful on a complete digit; rail1 carries the value.
    function automatic logic dr_decode(input dual_rail_logic d);
        return d.rail1;
    endfunction

endpackage

// File: rtl/ncl_completion.sv
// Completion detector for an N-digit dual-rail vector: all DATA, all NULL, any illegal.
module ncl_completion
    import ncl_pkg::*;
#(
    parameter int unsigned N = 6
) (
    input  dual_rail_logic [N-1:0] din,
    output logic                   all_data,
    output logic                   all_null,
    output logic                   any_illegal
);

    always_comb begin
        all_data    = 1'b1;
        all_null    = 1'b1;
        any_illegal = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (din[i].rail1 == din[i].rail0) all_data = 1'b0;
            if (din[i] != DR_NULL)            all_null = 1'b0;
            if (din[i] == DR_ILLEGAL)         any_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ncl_seq_mult.sv
// W-digit dual-rail shift-add multiplier with four-phase Ki/Ko handshake.
// Optional debug taps on latched operands and accumulator: define NCL_SEQMULT_DBG_EN.
module ncl_seq_mult
    import ncl_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  dual_rail_logic [W-1:0]   Ai,
    input  dual_rail_logic [W-1:0]   Bi,
    input  logic                     Ki,
    output dual_rail_logic [2*W-1:0] Po,
    output logic                     Ko,
    output logic                     err
`ifdef NCL_SEQMULT_DBG_EN
    ,
    output dual_rail_logic [W-1:0]   dbg_A,
    output dual_rail_logic [W-1:0]   dbg_B,
    output dual_rail_logic [2*W-1:0] dbg_M
`endif
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W);

    dual_rail_logic [PW-1:0] ab_dr;
    logic all_data, all_null, any_illegal;

    mult_state_e state_q, state_d;
    logic load, step, emit, retire;

    logic [W-1:0]  a_bits, b_bits;
    logic [W-1:0]  a_q, b_q;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    dual_rail_logic [PW-1:0] po_q, po_data;
    logic ko_q, err_q;

    assign ab_dr = {Ai, Bi};

    ncl_completion #(.N(PW)) u_completion (
        .din         (ab_dr),
        .all_data    (all_data),
        .all_null    (all_null),
        .any_illegal (any_illegal)
    );

    // Operand values, only latched on a complete DATA word.
    always_comb begin
        a_bits = '0;
        b_bits = '0;
        for (int i = 0; i < int'(W); i++) begin
            a_bits[i] = dr_decode(Ai[i]);
            b_bits[i] = dr_decode(Bi[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        emit    = 1'b0;
        retire  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (all_data) begin
                    load    = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                step = 1'b1;
                if (cnt_q == CW'(W - 1)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (Ki) begin
                    emit    = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!Ki && all_null) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One partial product per MUL cycle, LSB of B first.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (step) begin
            if (b_q[cnt_q]) acc_d = acc_q + (PW'(a_q) << cnt_q);
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        po_data = '0;
        for (int i = 0; i < int'(PW); i++) po_data[i] = dr_encode(acc_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            po_q  <= '0;
            ko_q  <= 1'b1;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (any_illegal) err_q <= 1'b1;
            if (load) begin
                a_q  <= a_bits;
                b_q  <= b_bits;
                ko_q <= 1'b0;
            end
            // Whole word switches in one edge, so Po is never mixed DATA/NULL.
            if (emit) po_q <= po_data;
            if (retire) begin
                po_q <= '0;
                ko_q <= 1'b1;
            end
        end
    end

    assign Po  = po_q;
    assign Ko  = ko_q;
    assign err = err_q;

`ifdef NCL_SEQMULT_DBG_EN
    dual_rail_logic [W-1:0]  dbg_a_q, dbg_b_q;
    dual_rail_logic [PW-1:0] dbg_m_q, m_enc;

    always_comb begin
        m_enc = '0;
        for (int i = 0; i < int'(PW); i++) m_enc[i] = dr_encode(acc_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_a_q <= '0;
            dbg_b_q <= '0;
            dbg_m_q <= '0;
        end else begin
            if (load) begin
                dbg_a_q <= Ai;
                dbg_b_q <= Bi;
            end
            if (load || step) dbg_m_q <= m_enc;
        end
    end

    assign dbg_A = dbg_a_q;
    assign dbg_B = dbg_b_q;
    assign dbg_M = dbg_m_q;
`endif

endmodule

// File: tb/tb_ncl_seq_mult.sv
// Self-checking bench for ncl_seq_mult: directed corner cases plus randomized operands.
module tb_ncl_seq_mult;
    import ncl_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned AW = 2 * W;
    localparam int unsigned QW = 2 * PW;

    logic clk = 1'b0;
    logic rst;
    dual_rail_logic [W-1:0]  Ai, Bi;
    logic Ki;
    dual_rail_logic [PW-1:0] Po;
    logic Ko, err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

`ifdef NCL_SEQMULT_DBG_EN
    dual_rail_logic [W-1:0]  dbg_A, dbg_B;
    dual_rail_logic [PW-1:0] dbg_M;
`endif

    ncl_seq_mult #(.W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .Ai   (Ai),
        .Bi   (Bi),
        .Ki   (Ki),
        .Po   (Po),
        .Ko   (Ko),
        .err  (err)
`ifdef NCL_SEQMULT_DBG_EN
        ,
        .dbg_A(dbg_A),
        .dbg_B(dbg_B),
        .dbg_M(dbg_M)
`endif
    );

    // Reference dual-rail word: "1" is rail1/rail0 = 10, "0" is 01, digit i at bits [2i+1:2i].
    function automatic logic [63:0] dr_word(input logic [31:0] v, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] a, input logic [31:0] b);
        Ai = AW'(dr_word(a, W));
        Bi = AW'(dr_word(b, W));
    endtask

    task automatic set_null();
        Ai = '0;
        Bi = '0;
    endtask

    // hold_mode: 0 plain, 1 inputs NULL with Ki still high, 2 Ki low with inputs still DATA.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int ki_delay, input int hold_mode);
        logic [63:0] prod;
        prod = dr_word(a * b, PW);
        set_data(a, b);
        Ki = (ki_delay == 0);
        tick();
        check("ko_fall", 64'(Ko), 64'(1'b0));
        repeat (W) tick();
        check("po_null_in_mul", QW'(Po), '0);
        if (ki_delay > 0) begin
            repeat (ki_delay) tick();
            check("po_null_in_wait", QW'(Po), '0);
            Ki = 1'b1;
        end
        tick();
        check("product", 64'(QW'(Po)), prod);
        if (hold_mode == 1) begin
            set_null();
            repeat (3) tick();
            check("hold_null_ki1", 64'(QW'(Po)), prod);
        end else if (hold_mode == 2) begin
            Ki = 1'b0;
            repeat (3) tick();
            check("hold_ki0_data", 64'(QW'(Po)), prod);
            check("hold_ko_low", 64'(Ko), 64'(1'b0));
        end
        set_null();
        Ki = 1'b0;
        tick();
        check("po_null_return", QW'(Po), '0);
        check("ko_rise", 64'(Ko), 64'(1'b1));
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1;
        Ki  = 1'b0;
        set_null();
        repeat (2) tick();
        check("reset_po", QW'(Po), '0);
        check("reset_ko", 64'(Ko), 64'(1'b1));
        check("reset_err", 64'(err), 64'(1'b0));
        rst = 1'b0;
        tick();

        run_op(2, 7, 0, 0);
        run_op(3, 5, 0, 0);
        run_op(4, 4, 0, 1);
        run_op(7, 7, 1, 2);
        run_op(0, 5, 0, 0);
        run_op(255, 255, 0, 0);
        run_op(255, 1, 20, 1);
        run_op(1, 0, 0, 2);

        // Partial word: A DATA, B NULL must not start a multiply.
        Ai = AW'(dr_word(32'd9, W));
        Bi = '0;
        Ki = 1'b1;
        repeat (10) tick();
        check("partial_ko", 64'(Ko), 64'(1'b1));
        check("partial_po", QW'(Po), '0);
        run_op(9, 13, 0, 0);

        for (int i = 0; i < 25; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            run_op(ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Illegal digit: sticky err and no FSM advance.
        set_data(5, 3);
        Bi[1] = DR_ILLEGAL;
        Ki = 1'b1;
        tick();
        check("illegal_err", 64'(err), 64'(1'b1));
        tick();
        check("illegal_ko_idle", 64'(Ko), 64'(1'b1));
        check("illegal_po_null", QW'(Po), '0);
        set_data(9, 9);
        tick();
        check("err_sticky", 64'(err), 64'(1'b1));
        check("ko_fall_after_illegal", 64'(Ko), 64'(1'b0));
        repeat (2) tick();
        rst = 1'b1;
        set_null();
        tick();
        check("rst_mid_mul_po", QW'(Po), '0);
        check("rst_mid_mul_ko", 64'(Ko), 64'(1'b1));
        check("rst_mid_mul_err", 64'(err), 64'(1'b0));
        rst = 1'b0;
        Ki = 1'b0;
        repeat (W + 3) tick();
        check("no_stale_product", QW'(Po), '0);
        run_op(6, 7, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ncl_seq_mult.md
# ncl_seq_mult

Clocked, parametrised successor to the 3×3 NCL multiplier. It accepts two W-digit unsigned dual-rail operands under the four-phase NCL DATA/NULL protocol (Ki/Ko), multiplies them with a W-cycle shift-add datapath, and returns a 2W-digit dual-rail product. It sits between dual-rail producer/consumer stages where a synchronous clock domain is available. It replaces the fixed 3-bit combinational array with a width-scalable iterative core.

## Interface

- W, default 3, operand width in digits; legal range 2..16.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- Ai  input  dual_rail_logic [W-1:0]  operand A; rail1=1/rail0=0 is "1", 01 is "0", 00 is NULL, 11 is illegal.
- Bi  input  dual_rail_logic [W-1:0]  operand B, same encoding.
- Ki  input  1  consumer request: 1 = request DATA, 0 = request NULL.
- Po  output  dual_rail_logic [2W-1:0]  product, unsigned A×B.
- Ko  output  1  producer request: 1 = ready for DATA, 0 = request NULL.
- err  output  1  sticky flag: an illegal (11) digit was sampled.

## Operation

- Completeness: DATA = every digit of Ai and Bi is 01 or 10. NULL = every digit is 00. Anything else is partial and does not advance the FSM.
- States:
  - IDLE: Ko=1, Po=NULL. On a complete DATA sample, latch A,B, clear accumulator, load count=0, set Ko=0, go to MUL.
  - MUL: each cycle, if B[count] then acc += A<<count; count++. After W cycles go to WAIT.
  - WAIT: Po=NULL. If Ki=1, drive Po = acc as DATA and go to HOLD.
  - HOLD: Po holds DATA. When Ki=0 and inputs are NULL in the same sample, set Po=NULL and Ko=1, and go to IDLE.
- Arithmetic: unsigned. acc is 2W bits wide; the maximum (2^W-1)^2 fits, so there is no overflow.
- Inputs are ignored in MUL and WAIT. Ki is ignored outside WAIT and HOLD.
- Illegal digit sampled in any state: err←1 (sticky until rst). The word is treated as partial, so the FSM does not advance on it.
- Ki=0 while in HOLD but inputs not yet NULL: stay in HOLD with Po DATA.
- Inputs NULL but Ki=1 in HOLD: stay in HOLD.
- Po never shows a mixed DATA/NULL word. All Po digits change in the same cycle.

## Timing

- Reset values: Po all 00, Ko=1, err=0, state IDLE, acc=0, count=0, dbg outputs 00.
- rst asserted at any point, including mid-MUL or in HOLD, forces the reset values at the next edge. No partial product is ever emitted.
- DATA first sampled complete at edge k: Ko falls after edge k. MUL occupies edges k+1..k+W. If Ki=1, Po is DATA after edge k+W+1, giving a latency of W+1 cycles.
- Ki=1 arriving later than that: Po becomes DATA one edge after Ki is first sampled high in WAIT.
- Return to NULL: Po is NULL and Ko=1 one edge after the first sample with Ki=0 and inputs NULL.
- Minimum period per operand is W+3 cycles.

## Configuration

- NCL_SEQMULT_DBG_EN defined:
  - adds output dbg_A, dual_rail_logic [W-1:0], the latched A;
  - adds output dbg_B, dual_rail_logic [W-1:0], the latched B;
  - adds output dbg_M, dual_rail_logic [2W-1:0], the live accumulator;
  - all three are dual-rail encoded, valid from IDLE exit, and 00 at reset.
- Not defined: these ports and their registers are absent. Functional behaviour is identical.

## Structure

- Package ncl_pkg holds:
  - typedef dual_rail_logic (struct: rail1, rail0);
  - constants DR_NULL, DR_ZERO, DR_ONE, DR_ILLEGAL;
  - functions dr_encode(bit) and dr_decode.
- Sub-module ncl_completion #(N):
  - inputs: dual-rail vector;
  - outputs: all_data, all_null, any_illegal;
  - instantiated once on the concatenation {Ai,Bi}.
- The FSM and shift-add datapath stay in ncl_seq_mult.

## Test plan

- W=3, A=2, B=7, Ki=1: Po rail1=001110, rail0=110001 (14) after 4 cycles. Then inputs NULL with Ki=0 → Po=NULL and Ko=1 next edge.
- W=3, back-to-back cycles 3×5, 4×4, 7×7, 0×5: products 15, 16, 49, 0. For 0, all Po digits are 01 (not NULL).
- W=8, A=255, B=255 → product 65025. W=16, A=65535, B=1 → product 65535.
- Partial input (A complete, B all NULL) held 10 cycles → Ko stays 1 and Po stays NULL. Completing B then starts MUL.
- Ki held 0 for 20 cycles after MUL → Po stays NULL. Ki↑ → Po DATA the next edge. Inputs NULL with Ki still 1 → HOLD persists.
- Bi[1]=11 → err=1 and the FSM stays in IDLE. Then rst asserted during MUL of a valid operand → Po NULL, Ko=1, err=0 after the next edge.
